// File: rtl/axi_stream_extract_header.sv
// -----------------------------------------------------------------------------
// axi_stream_extract_header
//
// Strips a per-packet header of H bytes off the front of an AXI Stream packet.
// The header goes out on its own channel. The remaining payload is re-aligned
// so that it starts at byte 0 of the output beats. Byte 0 of a beat is
// data[DATA_WD-1 -: 8], and keep is a run of ones starting at the MSB.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   valid_cfg / ready_cfg    header length handshake (byte_extract_cnt = H)
//   byte_extract_cnt         H in bytes; 0 or > DATA_BYTE_WD means DATA_BYTE_WD
//   *_in                     input stream (valid/data/keep/last, ready_in)
//   *_header                 extracted header channel, bytes MSB-aligned
//   *_out                    re-aligned payload stream
//   err_short                one-cycle pulse: first beat held fewer than H bytes
// -----------------------------------------------------------------------------
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_cfg,
    input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
    output logic                    ready_cfg,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    err_short
);

    typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

    state_t                  state, state_nxt;
    logic [BYTE_CNT_WD-1:0]  h_len, h_len_nxt;
    logic [DATA_WD-1:0]      resid, resid_nxt;
    logic [BYTE_CNT_WD-1:0]  flush_cnt, flush_cnt_nxt;
    logic                    err_nxt;

    logic                    out_load;
    logic [DATA_WD-1:0]      out_data_nxt;
    logic [DATA_BYTE_WD-1:0] out_keep_nxt;
    logic                    out_last_nxt;
    logic                    hdr_load;
    logic [DATA_WD-1:0]      hdr_data_nxt;
    logic [DATA_BYTE_WD-1:0] hdr_keep_nxt;

    logic [BYTE_CNT_WD-1:0]  cfg_h;
    logic [DATA_WD-1:0]      din;
    logic [DATA_WD-1:0]      din_tail;
    int                      h, r, k;

    // n ones starting at the MSB of a keep vector (n = DATA_BYTE_WD gives all ones).
    function automatic logic [DATA_BYTE_WD-1:0] msb_ones(input int n);
        return ~({DATA_BYTE_WD{1'b1}} >> n);
    endfunction

    // Expand a keep vector into a bit mask over the data bus.
    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] keep);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{keep[i]}};
        return m;
    endfunction

    function automatic int count_ones(input logic [DATA_BYTE_WD-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < DATA_BYTE_WD; i++) n += int'(keep[i]);
        return n;
    endfunction

    assign cfg_h = (byte_extract_cnt == '0 || int'(byte_extract_cnt) > DATA_BYTE_WD)
                 ? BYTE_CNT_WD'(DATA_BYTE_WD) : byte_extract_cnt;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_nxt     = state;
        h_len_nxt     = h_len;
        resid_nxt     = resid;
        flush_cnt_nxt = flush_cnt;
        err_nxt       = 1'b0;
        out_load      = 1'b0;
        out_data_nxt  = '0;
        out_keep_nxt  = '0;
        out_last_nxt  = 1'b0;
        hdr_load      = 1'b0;
        hdr_data_nxt  = '0;
        hdr_keep_nxt  = '0;

        h = int'(h_len);
        r = DATA_BYTE_WD - h;
        k = count_ones(keep_in);

        // Bytes outside keep are forced to zero so they never leak downstream.
        din      = data_in & byte_mask(keep_in);
        // Bytes left over after dropping the first H; a shift of the full width yields zero.
        din_tail = din << (h * 8);

        ready_cfg = (state == IDLE);
        ready_in  = (state == HDR || state == BODY) && (!valid_out || ready_out)
                 && (state != HDR || !valid_header);

        unique case (state)
            IDLE: begin
                if (valid_cfg) begin
                    h_len_nxt = cfg_h;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (valid_in && ready_in) begin
                    hdr_load     = 1'b1;
                    hdr_keep_nxt = msb_ones(h) & keep_in;
                    hdr_data_nxt = din & byte_mask(hdr_keep_nxt);
                    resid_nxt    = din_tail;
                    err_nxt      = (k < h);
                    if (last_in) begin
                        if (k > h) begin
                            out_load     = 1'b1;
                            out_data_nxt = din_tail;
                            out_keep_nxt = msb_ones(k - h);
                            out_last_nxt = 1'b1;
                        end
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = BODY;
                    end
                end
            end
            BODY: begin
                if (valid_in && ready_in) begin
                    // Residual R bytes followed by the first DATA_BYTE_WD-R new bytes.
                    out_load     = 1'b1;
                    out_data_nxt = resid | (din >> (r * 8));
                    out_keep_nxt = '1;
                    resid_nxt    = din_tail;
                    if (last_in) begin
                        if (r + k <= DATA_BYTE_WD) begin
                            out_keep_nxt = msb_ones(r + k);
                            out_last_nxt = 1'b1;
                            state_nxt    = IDLE;
                        end else begin
                            flush_cnt_nxt = BYTE_CNT_WD'(r + k - DATA_BYTE_WD);
                            state_nxt     = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (!valid_out || ready_out) begin
                    out_load     = 1'b1;
                    out_data_nxt = resid;
                    out_keep_nxt = msb_ones(int'(flush_cnt));
                    out_last_nxt = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are cleared too, so a reset mid-packet leaves no stale bytes visible.
            state        <= IDLE;
            h_len        <= '0;
            resid        <= '0;
            flush_cnt    <= '0;
            err_short    <= 1'b0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
        end else begin
            state     <= state_nxt;
            h_len     <= h_len_nxt;
            resid     <= resid_nxt;
            flush_cnt <= flush_cnt_nxt;
            err_short <= err_nxt;

            if (out_load) begin
                valid_out <= 1'b1;
                data_out  <= out_data_nxt;
                keep_out  <= out_keep_nxt;
                last_out  <= out_last_nxt;
            end else if (valid_out && ready_out) begin
                valid_out <= 1'b0;
            end

            if (hdr_load) begin
                valid_header <= 1'b1;
                data_header  <= hdr_data_nxt;
                keep_header  <= hdr_keep_nxt;
            end else if (valid_header && ready_header) begin
                valid_header <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_extract_header
//
// Directed packets with literal expectations, then randomized packets checked
// against a byte-queue reference model: header = first min(H, L) bytes, payload
// = the remaining bytes regrouped four per beat, last beat possibly partial.
// -----------------------------------------------------------------------------
module tb_axi_stream_extract_header;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_cfg;
    logic [CW-1:0] byte_extract_cnt;
    logic          ready_cfg;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [BW-1:0] keep_in;
    logic          last_in;
    logic          ready_in;
    logic          valid_header;
    logic [DW-1:0] data_header;
    logic [BW-1:0] keep_header;
    logic          ready_header;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;
    logic          last_out;
    logic          ready_out;
    logic          err_short;

    axi_stream_extract_header #(.DATA_WD(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_cfg        (valid_cfg),
        .byte_extract_cnt (byte_extract_cnt),
        .ready_cfg        (ready_cfg),
        .valid_in         (valid_in),
        .data_in          (data_in),
        .keep_in          (keep_in),
        .last_in          (last_in),
        .ready_in         (ready_in),
        .valid_header     (valid_header),
        .data_header      (data_header),
        .keep_header      (keep_header),
        .ready_header     (ready_header),
        .valid_out        (valid_out),
        .data_out         (data_out),
        .keep_out         (keep_out),
        .last_out         (last_out),
        .ready_out        (ready_out),
        .err_short        (err_short)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    err_seen = 0;
    int    err_exp  = 0;
    beat_t exp_out[$];
    beat_t exp_hdr[$];

    bit rand_out  = 1'b0;
    bit stall_out = 1'b0;
    bit rand_hdr  = 1'b0;
    bit hdr_hold  = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] ones(input int n);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < n && i < BW; i++) v[BW-1-i] = 1'b1;
        return v;
    endfunction

    // Consumer-side ready signals change just after the rising edge.
    always @(posedge clk) begin
        #1;
        ready_out    = stall_out ? 1'b0 : (rand_out ? 1'($urandom_range(0, 1)) : 1'b1);
        ready_header = hdr_hold ? 1'b0 : (rand_hdr ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= rst;

    // Monitor: everything sampled on the falling edge; a valid&ready seen here
    // completes on the next rising edge.
    bit    prev_stall = 1'b0;
    beat_t prev_beat;
    beat_t e_out;
    beat_t e_hdr;
    always @(negedge clk) begin
        if (prev_stall && !rst_q) begin
            check("stall_valid_held", valid_out, 1'b1);
            check("stall_beat_held", {data_out, keep_out, last_out},
                  {prev_beat.data, prev_beat.keep, prev_beat.last});
        end
        prev_stall     = valid_out && !ready_out;
        prev_beat.data = data_out;
        prev_beat.keep = keep_out;
        prev_beat.last = last_out;

        if (valid_out && ready_out) begin
            check("payload_expected", exp_out.size() != 0, 1'b1);
            if (exp_out.size() != 0) begin
                e_out = exp_out.pop_front();
                check("payload_beat", {data_out, keep_out, last_out},
                      {e_out.data, e_out.keep, e_out.last});
            end
        end
        if (valid_header && ready_header) begin
            check("header_expected", exp_hdr.size() != 0, 1'b1);
            if (exp_hdr.size() != 0) begin
                e_hdr = exp_hdr.pop_front();
                check("header_beat", {data_header, keep_header}, {e_hdr.data, e_hdr.keep});
            end
        end
        if (err_short) err_seen++;
    end

    task automatic push_out(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.last = l;
        exp_out.push_back(b);
    endtask

    task automatic push_hdr(input logic [DW-1:0] d, input logic [BW-1:0] k);
        beat_t b;
        b.data = d; b.keep = k; b.last = 1'b0;
        exp_hdr.push_back(b);
    endtask

    // Called on a falling edge; returns on a falling edge.
    task automatic send_cfg(input logic [CW-1:0] cnt);
        int t;
        t = 0;
        valid_cfg        = 1'b1;
        byte_extract_cnt = cnt;
        while (!ready_cfg) begin
            @(negedge clk);
            if (++t > 5000) begin
                $display("FAIL cfg_timeout: ready_cfg never rose");
                $fatal(1, "cfg handshake timed out");
            end
        end
        @(negedge clk);
        valid_cfg = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        int t;
        t = 0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        while (!ready_in) begin
            @(negedge clk);
            if (++t > 5000) begin
                $display("FAIL input_timeout: ready_in never rose");
                $fatal(1, "input handshake timed out");
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Reference model plus driver for one packet given as a byte list.
    task automatic send_packet(input logic [CW-1:0] raw_h, input logic [7:0] pkt[$],
                               input bit block_chk);
        int            heff, len, n;
        logic [DW-1:0] d;
        logic [BW-1:0] kk;

        heff = (raw_h == 0 || int'(raw_h) > BW) ? BW : int'(raw_h);
        len  = pkt.size();
        n    = (heff < len) ? heff : len;

        d = '0;
        for (int i = 0; i < n; i++) d[DW-1-8*i -: 8] = pkt[i];
        push_hdr(d, ones(n));
        if (len < heff) err_exp++;
        for (int s = n; s < len; s += BW) begin
            d  = '0;
            kk = '0;
            for (int j = 0; j < BW && s + j < len; j++) begin
                d[DW-1-8*j -: 8] = pkt[s+j];
                kk[BW-1-j]       = 1'b1;
            end
            push_out(d, kk, s + BW >= len);
        end

        send_cfg(raw_h);
        if (block_chk) begin
            // Previous header is still held, so the first beat must wait.
            valid_in = 1'b1;
            data_in  = '0;
            keep_in  = '1;
            last_in  = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check("ready_in_blocked_by_header", ready_in, 1'b0);
            end
            hdr_hold = 1'b0;
        end
        for (int s = 0; s < len; s += BW) begin
            d  = '0;
            kk = '0;
            for (int j = 0; j < BW && s + j < len; j++) begin
                d[DW-1-8*j -: 8] = pkt[s+j];
                kk[BW-1-j]       = 1'b1;
            end
            send_beat(d, kk, s + BW >= len);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_out.size() != 0 || exp_hdr.size() != 0) begin
            @(negedge clk);
            if (++t > 5000) begin
                $display("FAIL drain_timeout: %0d payload / %0d header beats outstanding",
                         exp_out.size(), exp_hdr.size());
                $fatal(1, "drain timed out");
            end
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic void rand_bytes(input int len, output logic [7:0] pkt[$]);
        pkt = {};
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    endfunction

    logic [7:0] pkt[$];

    initial begin
        rst              = 1'b1;
        valid_cfg        = 1'b0;
        byte_extract_cnt = '0;
        valid_in         = 1'b0;
        data_in          = '0;
        keep_in          = '0;
        last_in          = 1'b0;
        ready_out        = 1'b1;
        ready_header     = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_valid_out", valid_out, 1'b0);
        check("reset_valid_header", valid_header, 1'b0);
        check("reset_ready_cfg", ready_cfg, 1'b1);
        check("reset_ready_in", ready_in, 1'b0);
        check("reset_out_regs", {data_out, keep_out, last_out, err_short}, '0);

        // H=1, ends with a partial beat that needs a flush cycle.
        push_hdr(32'hAA000000, 4'b1000);
        push_out(32'hBBCCDD11, 4'b1111, 1'b0);
        push_out(32'h22334455, 4'b1111, 1'b0);
        push_out(32'h66000000, 4'b1000, 1'b1);
        send_cfg(3'd1);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55660000, 4'b1100, 1'b1);
        wait_drain();

        // byte_extract_cnt=0 clamps to a whole-beat header: payload passes through.
        push_hdr(32'h01020304, 4'b1111);
        push_out(32'h05060708, 4'b1111, 1'b0);
        push_out(32'h090A0B0C, 4'b1111, 1'b1);
        send_cfg(3'd0);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b0);
        send_beat(32'h090A0B0C, 4'b1111, 1'b1);
        wait_drain();

        // H=2, single-beat packet.
        push_hdr(32'hAABB0000, 4'b1100);
        push_out(32'hCCDD0000, 4'b1100, 1'b1);
        send_cfg(3'd2);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b1);
        wait_drain();

        // H=3 but only two bytes arrive: short error, no payload.
        push_hdr(32'hAABB0000, 4'b1100);
        err_exp++;
        send_cfg(3'd3);
        send_beat(32'hAABB0000, 4'b1100, 1'b1);
        wait_drain();
        check("err_short_count_directed", err_seen, 1);

        // A pending header blocks the next packet's first beat.
        hdr_hold = 1'b1;
        rand_bytes(8, pkt);
        send_packet(3'd1, pkt, 1'b0);
        rand_bytes(12, pkt);
        send_packet(3'd1, pkt, 1'b1);
        wait_drain();

        // Long H=1 packets back to back with random consumer stalls.
        rand_out = 1'b1;
        rand_hdr = 1'b1;
        for (int p = 0; p < 4; p++) begin
            rand_bytes(49 * BW + int'($urandom_range(1, BW)), pkt);
            send_packet(3'd1, pkt, 1'b0);
        end
        // Random lengths and raw header counts, including clamped values 0, 5..7.
        for (int p = 0; p < 30; p++) begin
            rand_bytes(int'($urandom_range(1, 24)), pkt);
            send_packet(CW'($urandom_range(0, 7)), pkt, 1'b0);
        end
        wait_drain();
        rand_out = 1'b0;
        rand_hdr = 1'b0;

        // Reset in BODY while a payload beat is held by a stalled consumer.
        stall_out = 1'b1;
        push_hdr(32'h01020000, 4'b1100);
        send_cfg(3'd2);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b0);
        check("pre_reset_held_beat", {valid_out, data_out}, {1'b1, 32'h03040506});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_valid_out", valid_out, 1'b0);
        check("mid_reset_valid_header", valid_header, 1'b0);
        check("mid_reset_ready_cfg", ready_cfg, 1'b1);
        check("mid_reset_data_out", {data_out, keep_out, last_out}, '0);
        check("mid_reset_header_taken", exp_hdr.size(), 0);
        stall_out = 1'b0;
        rand_bytes(10, pkt);
        send_packet(3'd3, pkt, 1'b0);
        wait_drain();

        check("err_short_count_total", err_seen, err_exp);
        check("payload_queue_empty", exp_out.size(), 0);
        check("header_queue_empty", exp_hdr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
